// File: rtl/link_pipe_pkg.sv
// Shared constants and helpers for the elastic link register.
package link_pipe_pkg;

    localparam int LINK_DATA_WIDTH = 32;
    localparam int MAX_STAGES      = 8;

    // Occupancy must represent 0..2*stages inclusive.
    function automatic int occ_width(input int stages);
        return $clog2(2 * stages + 1);
    endfunction

endpackage

// File: rtl/link_pipe_stage.sv
// One main+skid elastic stage; up_ready is purely registered so stages
// chain without a combinational ready path.
module link_pipe_stage
    import link_pipe_pkg::*;
#(
    parameter int DATA_WIDTH = LINK_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  up_valid,
    input  logic [DATA_WIDTH-1:0] up_data,
    output logic                  up_ready,
    output logic                  dn_valid,
    output logic [DATA_WIDTH-1:0] dn_data,
    input  logic                  dn_ready
);

    logic                  m_valid;
    logic                  s_valid;
    logic [DATA_WIDTH-1:0] m_data;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  accept;

    assign up_ready = ~s_valid;
    assign dn_valid = m_valid;
    assign dn_data  = m_data;
    assign accept   = up_valid & ~s_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid <= 1'b0;
            s_valid <= 1'b0;
            m_data  <= '0;
            s_data  <= '0;
        end else if (flush) begin
            // Data registers keep their contents; only the valid bits clear.
            m_valid <= 1'b0;
            s_valid <= 1'b0;
        end else if (s_valid && dn_ready) begin
            m_data  <= s_data;
            m_valid <= 1'b1;
            s_valid <= 1'b0;
        end else if (accept && m_valid && !dn_ready) begin
            s_data  <= up_data;
            s_valid <= 1'b1;
        end else if (accept) begin
            m_data  <= up_data;
            m_valid <= 1'b1;
        end else if (m_valid && dn_ready) begin
            m_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/link_pipe.sv
// Parametrised elastic link register: STAGES chained skid stages with
// synchronous flush and a registered occupancy count.
module link_pipe
    import link_pipe_pkg::*;
#(
    parameter int DATA_WIDTH = LINK_DATA_WIDTH,
    parameter int STAGES     = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         in_valid,
    input  logic [DATA_WIDTH-1:0]        in_data,
    output logic                         in_ready,
    output logic                         out_valid,
    output logic [DATA_WIDTH-1:0]        out_data,
    input  logic                         out_ready,
    output logic [occ_width(STAGES)-1:0] occupancy
);

    localparam int OW = occ_width(STAGES);

    if (STAGES < 1 || STAGES > MAX_STAGES) begin : g_bad_stages
        $error("link_pipe: STAGES=%0d outside legal range 1..%0d", STAGES, MAX_STAGES);
    end

    // Index k is the upstream side of stage k; index STAGES is the link output.
    logic [STAGES:0]                 vld;
    logic [STAGES:0]                 rdy;
    logic [STAGES:0][DATA_WIDTH-1:0] dat;

    assign vld[0]      = in_valid;
    assign dat[0]      = in_data;
    assign rdy[STAGES] = out_ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        link_pipe_stage #(.DATA_WIDTH(DATA_WIDTH)) u_stage (
            .clk      (clk),
            .rst      (rst),
            .flush    (flush),
            .up_valid (vld[k]),
            .up_data  (dat[k]),
            .up_ready (rdy[k]),
            .dn_valid (vld[k+1]),
            .dn_data  (dat[k+1]),
            .dn_ready (rdy[k+1])
        );
    end

    assign in_ready  = rdy[0] & ~flush;
    assign out_valid = vld[STAGES];
    assign out_data  = dat[STAGES];

    logic accept;
    logic deliver;

    assign accept  = in_valid & in_ready;
    assign deliver = out_valid & out_ready;

    // Tracks the sum of all stage valid bits without an adder tree.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            occupancy <= '0;
        end else if (accept && !deliver) begin
            occupancy <= occupancy + OW'(1);
        end else if (deliver && !accept) begin
            occupancy <= occupancy - OW'(1);
        end
    end

endmodule

// File: tb/tb_link_pipe.sv
// Bench for link_pipe: four instances (STAGES 2,1,3,8) share stimulus and are
// checked every cycle against per-instance FIFO queues.
module tb_link_pipe;
    import link_pipe_pkg::*;

    localparam int ND = 4;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [31:0] in_data;

    logic [ND-1:0]       ir, ov;
    logic [ND-1:0][31:0] od;
    logic [ND-1:0][4:0]  oc;

    always #5 clk = ~clk;

    function automatic int stg(input int i);
        return (i == 0) ? 2 : (i == 1) ? 1 : (i == 2) ? 3 : 8;
    endfunction

    for (genvar g = 0; g < ND; g++) begin : g_dut
        localparam int STG = (g == 0) ? 2 : (g == 1) ? 1 : (g == 2) ? 3 : 8;
        logic [occ_width(STG)-1:0] occ_w;
        link_pipe #(.DATA_WIDTH(32), .STAGES(STG)) dut (
            .clk       (clk),
            .rst       (rst),
            .flush     (flush),
            .in_valid  (in_valid),
            .in_data   (in_data),
            .in_ready  (ir[g]),
            .out_valid (ov[g]),
            .out_data  (od[g]),
            .out_ready (out_ready),
            .occupancy (occ_w)
        );
        assign oc[g] = 5'(occ_w);
    end

    logic [31:0] q [ND][$];
    int          dlv   [ND];
    int          waitc [ND];
    int          n_vec = 0;
    int          n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: apply the handshakes that the coming edge will perform.
    task automatic record();
        for (int i = 0; i < ND; i++) begin
            if (rst) begin
                q[i].delete();
            end else begin
                if (ov[i] && out_ready && q[i].size() > 0) begin
                    void'(q[i].pop_front());
                    dlv[i]++;
                end
                if (flush) q[i].delete();
                else if (in_valid && ir[i]) q[i].push_back(in_data);
            end
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < ND; i++) begin
            chk($sformatf("occupancy[%0d]", i), 32'(oc[i]), 32'(q[i].size()));
            if (q[i].size() == 0) begin
                chk($sformatf("idle_out_valid[%0d]", i), 32'(ov[i]), 32'd0);
                if (!flush) chk($sformatf("empty_in_ready[%0d]", i), 32'(ir[i]), 32'd1);
                waitc[i] = 0;
            end else if (ov[i]) begin
                chk($sformatf("head_data[%0d]", i), od[i], q[i][0]);
                waitc[i] = 0;
            end else begin
                waitc[i]++;
                chk($sformatf("head_late[%0d]", i), 32'(waitc[i] > stg(i) - 1), 32'd0);
            end
            if (q[i].size() == 2 * stg(i))
                chk($sformatf("full_in_ready[%0d]", i), 32'(ir[i]), 32'd0);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic ordy,
                         input logic fl, input logic r);
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        rst       = r;
    endtask

    task automatic edge_step();
        #1;
        record();
        @(negedge clk);
        compare_all();
    endtask

    task automatic step(input logic v, input logic [31:0] d, input logic ordy,
                        input logic fl, input logic r);
        drive(v, d, ordy, fl, r);
        edge_step();
    endtask

    task automatic drain();
        logic empty;
        empty = 1'b0;
        drive(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
        for (int n = 0; n < 40 && !empty; n++) begin
            edge_step();
            empty = 1'b1;
            for (int i = 0; i < ND; i++)
                if (q[i].size() != 0 || ov[i]) empty = 1'b0;
        end
        chk("drain_done", 32'(empty), 32'd1);
    endtask

    initial begin
        logic [ND-1:0] done;
        int            cyc;
        for (int i = 0; i < ND; i++) begin
            dlv[i]   = 0;
            waitc[i] = 0;
        end
        drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);

        // Reset state
        step(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b1);
        chk("rst_out_valid", 32'(ov[0]), 32'd0);
        chk("rst_out_data", od[0], 32'd0);
        chk("rst_occupancy", 32'(oc[0]), 32'd0);
        step(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
        chk("rst_in_ready", 32'(ir[0]), 32'd1);

        // Streaming at full rate
        for (int k = 1; k <= 16; k++) begin
            step(1'b1, 32'(k), 1'b1, 1'b0, 1'b0);
            chk("stream_in_ready", 32'(ir[0]), 32'd1);
            if (k == 1) begin
                chk("stream_latency", 32'(ov[0]), 32'd0);
            end else begin
                chk("stream_valid", 32'(ov[0]), 32'd1);
                chk("stream_data", od[0], 32'(k - 1));
            end
        end
        drain();

        // Backpressure: capacity 2*STAGES, then recovery
        for (int k = 1; k <= 6; k++) begin
            step(1'b1, 32'h100 + 32'(k), 1'b0, 1'b0, 1'b0);
            if (k == 3) chk("bp_ready_before_full", 32'(ir[0]), 32'd1);
            if (k >= 4) begin
                chk("bp_in_ready", 32'(ir[0]), 32'd0);
                chk("bp_occupancy", 32'(oc[0]), 32'd4);
            end
        end
        chk("bp_head", od[0], 32'h101);
        for (int j = 1; j <= 4; j++) begin
            step(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
            if (j <= 3) chk("bp_drain_data", od[0], 32'h101 + 32'(j));
            if (j == 2) chk("bp_ready_recover", 32'(ir[0]), 32'd1);
            if (j == 4) chk("bp_drain_empty", 32'(ov[0]), 32'd0);
        end
        drain();

        // Flush with 3 flits held
        for (int k = 1; k <= 3; k++) step(1'b1, 32'h200 + 32'(k), 1'b0, 1'b0, 1'b0);
        chk("flush_pre_occ", 32'(oc[0]), 32'd3);
        drive(1'b1, 32'h2FF, 1'b1, 1'b1, 1'b0);
        #1;
        chk("flush_in_ready", 32'(ir[0]), 32'd0);
        chk("flush_head_valid", 32'(ov[0]), 32'd1);
        chk("flush_head_data", od[0], 32'h201);
        edge_step();
        chk("flush_occ", 32'(oc[0]), 32'd0);
        chk("flush_out_valid", 32'(ov[0]), 32'd0);
        step(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);

        // Reset mid-stream, then a fresh flit with normal latency
        for (int k = 1; k <= 3; k++) step(1'b1, 32'h300 + 32'(k), 1'b0, 1'b0, 1'b0);
        chk("mrst_pre_occ", 32'(oc[0]), 32'd3);
        step(1'b1, 32'h3FF, 1'b1, 1'b0, 1'b1);
        chk("mrst_out_valid", 32'(ov[0]), 32'd0);
        chk("mrst_out_data", od[0], 32'd0);
        chk("mrst_occ", 32'(oc[0]), 32'd0);
        step(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
        chk("mrst_in_ready", 32'(ir[0]), 32'd1);
        step(1'b1, 32'hA5A5_A5A5, 1'b1, 1'b0, 1'b0);
        chk("mrst_latency", 32'(ov[0]), 32'd0);
        step(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
        chk("mrst_flit_valid", 32'(ov[0]), 32'd1);
        chk("mrst_flit_data", od[0], 32'hA5A5_A5A5);
        drain();

        // Random traffic until every instance has delivered 10000 flits
        for (int i = 0; i < ND; i++) dlv[i] = 0;
        done = '0;
        cyc  = 0;
        while (done != '1 && cyc < 60000) begin
            step(1'($urandom_range(1)), $urandom, 1'($urandom_range(1)), 1'b0, 1'b0);
            cyc++;
            for (int i = 0; i < ND; i++) done[i] = (dlv[i] >= 10000);
        end
        chk("random_flits_done", 32'(done), 32'(4'hF));
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
